// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle right shifter: FSM encoding, amount width, STEP legality.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SHRL_WIDTH = 32;
    localparam int SHRL_STEP  = 4;

    // Clamped amount needs one extra bit so that amt==WIDTH is representable.
    function automatic int shamt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic bit step_legal(input int width, input int step);
        return (step >= 1) && (step <= width) && ((step & (step - 1)) == 0);
    endfunction

    localparam int  SHAMT_W = shamt_w(SHRL_WIDTH);
    localparam bit  STEP_OK = step_legal(SHRL_WIDTH, SHRL_STEP);

endpackage

// File: rtl/shr_stage.sv
// One shift step: combinational right shift of the accumulator by k (0..STEP) with a fill bit.
module shr_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = SHRL_WIDTH,
    parameter int STEP  = SHRL_STEP
) (
    input  logic [WIDTH-1:0]        din,
    input  logic [$clog2(STEP):0]   k,
    input  logic                    fill,
    output logic [WIDTH-1:0]        dout
);

    logic [2*WIDTH-1:0] ext;

    always_comb begin
        ext  = {{WIDTH{fill}}, din};
        dout = WIDTH'(ext >> k);
    end

endmodule

// File: rtl/shrl_seq.sv
// Multi-cycle right shifter: accepts operand+amount on valid/ready, shifts STEP bits per cycle,
// holds the result until consumed. Define SHRL_ARITH_EN to add the arith port (sign fill).
module shrl_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = SHRL_WIDTH,
    parameter int STEP  = SHRL_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [31:0]      shift,
`ifdef SHRL_ARITH_EN
    input  logic             arith,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shifted,
    output logic             busy
);

    localparam int AMT_W  = shamt_w(WIDTH);
    localparam int STEP_W = $clog2(STEP) + 1;

    if (!step_legal(WIDTH, STEP)) begin : g_bad_step
        $error("shrl_seq: STEP must be a power of two in 1..WIDTH");
    end

    state_t             state, state_d;
    logic [WIDTH-1:0]   acc, acc_d;
    logic [AMT_W-1:0]   rem, rem_d;
    logic               fill, fill_d;
    logic [WIDTH-1:0]   res;

    logic [AMT_W-1:0]   amt;
    logic               fill_in;
    logic [STEP_W-1:0]  k;
    logic [WIDTH-1:0]   stage_out;

    // Any amount at or beyond WIDTH behaves exactly like WIDTH: everything shifted out.
    always_comb begin
        if (shift >= 32'(WIDTH))
            amt = AMT_W'(WIDTH);
        else
            amt = shift[AMT_W-1:0];
    end

`ifdef SHRL_ARITH_EN
    assign fill_in = arith & input1[WIDTH-1];
`else
    assign fill_in = 1'b0;
`endif

    always_comb begin
        if (rem >= AMT_W'(STEP))
            k = STEP_W'(STEP);
        else
            k = STEP_W'(rem);
    end

    shr_stage #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_stage (
        .din   (acc),
        .k     (k),
        .fill  (fill),
        .dout  (stage_out)
    );

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        rem_d     = rem;
        fill_d    = fill;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = input1;
                    rem_d   = amt;
                    fill_d  = fill_in;
                    state_d = (amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy  = 1'b1;
                acc_d = stage_out;
                rem_d = rem - AMT_W'(k);
                if (rem_d == '0)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // No bypass: a request seen while retiring waits for IDLE.
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            rem   <= '0;
            fill  <= 1'b0;
            res   <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            rem   <= rem_d;
            fill  <= fill_d;
            // Result register is separate so it survives the next accept until that op completes.
            if (state_d == ST_DONE && state != ST_DONE)
                res <= acc_d;
        end
    end

    assign shifted = res;

endmodule

// File: tb/tb_shrl_seq.sv
// Directed bench for shrl_seq (WIDTH=32, STEP=4); arith cases enabled with SHRL_ARITH_EN.
module tb_shrl_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] shift;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] shifted;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    shrl_seq #(
        .WIDTH (32),
        .STEP  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .shift     (shift),
`ifdef SHRL_ARITH_EN
        .arith     (arith),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .shifted   (shifted),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble inputs after the accept edge, wait for out_valid.
    task automatic run(input string tag, input logic [31:0] op, input logic [31:0] sh,
                       input logic ar, input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        input1   = op;
        shift    = sh;
        arith    = ar;
        tick();
        in_valid = 1'b0;
        input1   = ~op;
        shift    = sh ^ 32'h5;
        arith    = ~ar;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, shifted, exp);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic retire(input string tag, input logic [31:0] exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ret_ov"}, 32'(out_valid), 32'd0);
        check({tag, "_ret_hold"}, shifted, exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        input1    = '0;
        shift     = '0;
        arith     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_shifted", shifted, 32'd0);

        run("logic4", 32'h800000F0, 32'd4, 1'b0, 32'h0800000F, 1);
        retire("logic4", 32'h0800000F);

        run("zero", 32'hDEADBEEF, 32'd0, 1'b0, 32'hDEADBEEF, 0);
        retire("zero", 32'hDEADBEEF);

        run("odd5", 32'h800000F0, 32'd5, 1'b0, 32'h04000007, 2);
        retire("odd5", 32'h04000007);

        run("over40", 32'h80000000, 32'd40, 1'b0, 32'h00000000, 8);
        retire("over40", 32'h00000000);

        run("sh31", 32'h80000000, 32'd31, 1'b0, 32'h00000001, 8);
        retire("sh31", 32'h00000001);

        run("shmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 8);
        retire("shmax", 32'h00000000);

`ifdef SHRL_ARITH_EN
        run("arith10", 32'hF0000000, 32'd10, 1'b1, 32'hFFFC0000, 3);
        retire("arith10", 32'hFFFC0000);
        run("arith40", 32'h80000000, 32'd40, 1'b1, 32'hFFFFFFFF, 8);
        retire("arith40", 32'hFFFFFFFF);
        run("arith_pos", 32'h70000000, 32'd8, 1'b1, 32'h00700000, 2);
        retire("arith_pos", 32'h00700000);
`endif

        // Backpressure: result held, new requests ignored while DONE.
        run("bp", 32'h12345678, 32'd8, 1'b0, 32'h00123456, 2);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            input1   = 32'hAAAA5555;
            shift    = 32'd1;
            tick();
            check("bp_hold", shifted, 32'h00123456);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b1;
        input1    = 32'hFFFF0000;
        shift     = 32'd16;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ret_idle", 32'(in_ready), 32'd1);
        check("bp_ret_ov", 32'(out_valid), 32'd0);
        check("bp_ret_busy", 32'(busy), 32'd0);
        run("bp_next", 32'hFFFF0000, 32'd16, 1'b0, 32'h0000FFFF, 4);
        retire("bp_next", 32'h0000FFFF);

        // Reset during the third SHIFT cycle of a long op.
        in_valid = 1'b1;
        input1   = 32'h80000000;
        shift    = 32'd31;
        tick();
        in_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("mid_still_shift", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_shifted", shifted, 32'd0);
        check("mid_busy_low", 32'(busy), 32'd0);

        run("post_rst", 32'h0000F000, 32'd12, 1'b0, 32'h0000000F, 3);
        retire("post_rst", 32'h0000000F);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
